sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the dual 32x512 SRAM pair (64-bit word; port 0 write-only, port 1 read-only) between two requesters: index 0 = calculator controller, index 1 = host/debug loader.
- Read and write ports are arbitrated independently, so one write and one read can issue in the same cycle.
- Each port uses round-robin arbitration.
- The block blocks same-address read/write collisions and routes returned read data to the requester that issued the read.
- Sits between the requesters and the SRAM_A/SRAM_B port pins in top_lvl.

Parameters:
- ADDR_W, 9, SRAM word address width.
- MEM_WORD_SIZE, 64, data width (SRAM_B supplies bits 63:32, SRAM_A bits 31:0).
- RD_LAT, 1, cycles from read grant to valid r_data_i.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  2  per-requester access request.
- we_i  in  2  per-requester op type: 1 = write, 0 = read.
- addr_i  in  2xADDR_W  per-requester address.
- wdata_i  in  2xMEM_WORD_SIZE  per-requester write data.
- gnt_o  out  2  access accepted this cycle; transfer occurs when req_i[k] and gnt_o[k] are both high.
- rvalid_o  out  2  read data valid for requester k.
- rdata_o  out  MEM_WORD_SIZE  returned read data, qualified by rvalid_o.
- write_o  out  1  SRAM port-0 write strobe (top drives csb0/web0 = ~write_o).
- w_addr_o  out  ADDR_W  port-0 address.
- w_data_o  out  MEM_WORD_SIZE  port-0 data.
- read_o  out  1  SRAM port-1 read strobe (csb1 = ~read_o).
- r_addr_o  out  ADDR_W  port-1 address.
- r_data_i  in  MEM_WORD_SIZE  port-1 data.

Behaviour:
- **Reset (rst_i high at clk_i edge):**
  - wr_ptr = 0, rd_ptr = 0.
  - Read-owner pipeline cleared.
  - rvalid_o = 0, rdata_o = 0.
- **Combinational outputs, all 0 while rst_i is high:** gnt_o, write_o, read_o, w_addr_o, w_data_o, r_addr_o.
- **Write arbitration (combinational):**
  - Candidates are requesters with req_i & we_i.
  - If both are candidates, the requester indexed by wr_ptr wins; otherwise the single candidate wins.
  - The winner drives w_addr_o and w_data_o, write_o = 1, gnt_o[winner] = 1.
  - With no candidate: write_o = 0, w_addr_o = 0, w_data_o = 0.
- **Read arbitration (combinational):**
  - Same scheme, using req_i & ~we_i and rd_ptr.
  - The winner drives r_addr_o, read_o = 1, gnt_o[winner] = 1.
- **Pointer update:**
  - On a granted write, wr_ptr <= ~winner at the clock edge; same for rd_ptr on a granted read.
  - With no grant, the pointer holds.
  - This guarantees alternation under continuous contention and no starvation.
- **Collision rule:**
  - Applies when a write and a read would both be granted in the same cycle with equal addresses.
  - The read is suppressed: read_o = 0, no read gnt, rd_ptr holds.
  - The write proceeds.
  - The read requester retries and wins the next cycle, returning the newly written data.
- **Read return:**
  - The arbiter tracks the owner of each granted read in an RD_LAT-deep valid/owner shift pipeline.
  - RD_LAT cycles after the grant edge: rvalid_o[owner] = 1 and rdata_o = r_data_i, for exactly one cycle per granted read.
  - rvalid_o[1:0] is never 2'b11.
  - Back-to-back reads return back-to-back, in grant order.
- **Requester rules:**
  - A requester holds req_i, we_i, addr_i and wdata_i stable until granted.
  - Dropping req_i before grant is permitted and has no side effect.
  - Dropping req_i in the same cycle as an arbitration decision means no grant is issued to that requester.
- **Latency:**
  - Grant has zero-cycle latency when uncontended; the write lands at the grant edge.
  - Worst-case wait under contention is 1 cycle on a port, plus 1 cycle extra for a colliding read.
- **Reset mid-operation:**
  - In-flight reads are discarded and no rvalid_o fires for them after reset.
  - Pointers return to 0.

Test Plan:
- Single writes then reads, no contention:
  - Req0 writes addr 0x010 data 0x0123456789ABCDEF -> gnt_o = 01, write_o = 1, w_addr_o = 0x010.
  - Next cycle req0 reads 0x010 -> rvalid_o = 01 RD_LAT later, rdata_o = 0x0123456789ABCDEF.
- Write contention:
  - Both requesters hold write requests for 4 cycles (addr 0x001–0x004) after reset.
  - Required gnt_o sequence: 01, 10, 01, 10.
  - Memory holds each requester's data at its addresses.
- Concurrent read + write, different addresses:
  - Req0 writes 0x020 while req1 reads 0x030 (preloaded 0xDEADBEEF00000001).
  - Required: gnt_o = 11; rvalid_o = 10 with 0xDEADBEEF00000001 one cycle later.
- Collision:
  - Req0 writes 0x040 = 0xAAAA...; same cycle req1 reads 0x040 (old value 0x5555...).
  - Required: gnt_o = 01 first cycle, gnt_o = 10 the next cycle.
  - rdata_o = 0xAAAAAAAAAAAAAAAA with rvalid_o = 10.
- Read stream interleave:
  - Both requesters stream reads of 0x100.. and 0x200..
  - Required: rvalid_o alternates 01/10 with matching data.
  - rvalid_o is never 11 and no return is lost or duplicated.
- Reset mid-read:
  - Grant a read, assert rst_i on the following edge.
  - Required: no rvalid_o after reset, all outputs 0, and the next contended grant goes to requester 0.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter.
//   req_i    : per-requester access request (index 0 = calc ctrl, 1 = loader)
//   we_i     : per-requester op type, 1 = write, 0 = read
//   addr_i   : per-requester word address
//   wdata_i  : per-requester write data
//   gnt_o    : access accepted this cycle (transfer when req_i & gnt_o)
//   rvalid_o : read data valid for requester k
//   rdata_o  : returned read data, qualified by rvalid_o
// master = requester side, slave = arbiter side.
interface sram_port_arbiter_if #(
    parameter int ADDR_W        = 9,
    parameter int MEM_WORD_SIZE = 64
);
    logic [1:0]                    req_i;
    logic [1:0]                    we_i;
    logic [1:0][ADDR_W-1:0]        addr_i;
    logic [1:0][MEM_WORD_SIZE-1:0] wdata_i;
    logic [1:0]                    gnt_o;
    logic [1:0]                    rvalid_o;
    logic [MEM_WORD_SIZE-1:0]      rdata_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of the SRAM_A/SRAM_B pair (port 0 write-only,
// port 1 read-only). Write and read ports are arbitrated independently with
// round-robin pointers, same-address read/write collisions are resolved in
// favour of the write, and read data is steered back to the issuing requester.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_if       : requester bus (slave side)
//   write_o, w_addr_o, w_data_o : SRAM port-0 strobe/address/data
//   read_o, r_addr_o            : SRAM port-1 strobe/address
//   r_data_i                    : SRAM port-1 data, RD_LAT cycles after read_o
module sram_port_arbiter #(
    parameter int ADDR_W        = 9,
    parameter int MEM_WORD_SIZE = 64,
    parameter int RD_LAT        = 1    // must be >= 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    sram_port_arbiter_if.slave       req_if,
    output logic                     write_o,
    output logic [ADDR_W-1:0]        w_addr_o,
    output logic [MEM_WORD_SIZE-1:0] w_data_o,
    output logic                     read_o,
    output logic [ADDR_W-1:0]        r_addr_o,
    input  logic [MEM_WORD_SIZE-1:0] r_data_i
);

    logic [1:0] wr_cand;
    logic [1:0] rd_cand;
    logic       wr_any;
    logic       rd_any;
    logic       wr_win;
    logic       rd_win;
    logic       collision;
    logic       wr_go;
    logic       rd_go;
    logic [1:0] gnt;
    logic [1:0] rvalid;

    logic       wr_ptr_reg, wr_ptr_next;
    logic       rd_ptr_reg, rd_ptr_next;

    // Owner tracking for reads in flight; the last stage lines up with r_data_i.
    logic [RD_LAT-1:0] pipe_valid_reg, pipe_valid_next;
    logic [RD_LAT-1:0] pipe_owner_reg, pipe_owner_next;

    // Arbitration decision
    always_comb begin
        wr_cand = req_if.req_i & req_if.we_i;
        rd_cand = req_if.req_i & ~req_if.we_i;
        wr_any  = |wr_cand;
        rd_any  = |rd_cand;
        // With a single candidate its index is simply bit 1 of the vector.
        wr_win  = (wr_cand == 2'b11) ? wr_ptr_reg : wr_cand[1];
        rd_win  = (rd_cand == 2'b11) ? rd_ptr_reg : rd_cand[1];
        // A read that targets the word being written this cycle would return
        // stale data; hold it back one cycle so it sees the new value.
        collision = wr_any && rd_any &&
                    (req_if.addr_i[wr_win] == req_if.addr_i[rd_win]);
        wr_go = wr_any && !rst_i;
        rd_go = rd_any && !collision && !rst_i;
    end

    // Round-robin pointers: after a grant, priority passes to the other requester.
    always_comb begin
        wr_ptr_next = wr_go ? ~wr_win : wr_ptr_reg;
        rd_ptr_next = rd_go ? ~rd_win : rd_ptr_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            pipe_valid_reg <= '0;
            pipe_owner_reg <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            pipe_valid_reg <= pipe_valid_next;
            pipe_owner_reg <= pipe_owner_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_head
                assign pipe_valid_next[gi] = rd_go;
                assign pipe_owner_next[gi] = rd_win;
            end else begin : g_tail
                assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
                assign pipe_owner_next[gi] = pipe_owner_reg[gi-1];
            end
        end
    endgenerate

    // SRAM strobes and grants
    always_comb begin
        gnt      = '0;
        write_o  = 1'b0;
        w_addr_o = '0;
        w_data_o = '0;
        read_o   = 1'b0;
        r_addr_o = '0;
        if (wr_go) begin
            write_o     = 1'b1;
            w_addr_o    = req_if.addr_i[wr_win];
            w_data_o    = req_if.wdata_i[wr_win];
            gnt[wr_win] = 1'b1;
        end
        if (rd_go) begin
            read_o      = 1'b1;
            r_addr_o    = req_if.addr_i[rd_win];
            gnt[rd_win] = 1'b1;
        end
    end

    // Read return: one-hot by construction since only one read is in each stage.
    // A return landing in a reset cycle is dropped along with the pipeline.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rvalid
            assign rvalid[gi] = !rst_i && pipe_valid_reg[RD_LAT-1] &&
                                (pipe_owner_reg[RD_LAT-1] == 1'(gi));
        end
    endgenerate

    assign req_if.gnt_o    = gnt;
    assign req_if.rvalid_o = rvalid;
    assign req_if.rdata_o  = (|rvalid) ? r_data_i : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a transaction-level model
// (reference memory, round-robin priority, queue of pending read returns).
module tb_sram_port_arbiter;

    localparam int AW     = 9;
    localparam int DW     = 64;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_o, read_o;
    logic [AW-1:0] w_addr_o, r_addr_o;
    logic [DW-1:0] w_data_o;
    logic [DW-1:0] sram_rdata;

    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(AW), .MEM_WORD_SIZE(DW)) bus ();

    sram_port_arbiter #(.ADDR_W(AW), .MEM_WORD_SIZE(DW), .RD_LAT(RD_LAT)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_if   (bus),
        .write_o  (write_o),
        .w_addr_o (w_addr_o),
        .w_data_o (w_data_o),
        .read_o   (read_o),
        .r_addr_o (r_addr_o),
        .r_data_i (sram_rdata)
    );

    // SRAM emulation (environment): synchronous write, 1-cycle read.
    logic [DW-1:0] sram_mem [512];
    always @(posedge clk) begin
        if (pre_en)  sram_mem[pre_addr] <= pre_data;
        if (write_o) sram_mem[w_addr_o] <= w_data_o;
        if (read_o)  sram_rdata <= sram_mem[r_addr_o];
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int          owner;
        logic [63:0] data;
        int          due;
    } rd_t;

    rd_t         pend[$];
    logic [63:0] ref_mem [512];
    int          m_wptr = 0;
    int          m_rptr = 0;
    int          cyc = 0;

    always @(negedge clk) begin : model
        logic [1:0]    wc, rc, e_gnt, e_rv;
        logic          e_wr, e_rd;
        logic [AW-1:0] e_wa, e_ra;
        logic [63:0]   e_wd, e_rdata;
        int            ww, rw;
        e_gnt = '0; e_rv = '0; e_wr = 1'b0; e_rd = 1'b0;
        e_wa = '0; e_ra = '0; e_wd = '0; e_rdata = '0;
        wc = bus.req_i & bus.we_i;
        rc = bus.req_i & ~bus.we_i;
        ww = (wc == 2'b11) ? m_wptr : (wc[1] ? 1 : 0);
        rw = (rc == 2'b11) ? m_rptr : (rc[1] ? 1 : 0);
        if (rst) begin
            pend.delete();
            m_wptr = 0;
            m_rptr = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e_rv[pend[0].owner] = 1'b1;
                e_rdata = pend[0].data;
                void'(pend.pop_front());
            end
            if (wc != 2'b00) begin
                e_wr = 1'b1;
                e_wa = bus.addr_i[ww];
                e_wd = bus.wdata_i[ww];
                e_gnt[ww] = 1'b1;
            end
            if (rc != 2'b00 && !(e_wr && bus.addr_i[rw] == e_wa)) begin
                e_rd = 1'b1;
                e_ra = bus.addr_i[rw];
                e_gnt[rw] = 1'b1;
                pend.push_back('{owner: rw, data: ref_mem[e_ra], due: cyc + RD_LAT});
                m_rptr = 1 - rw;
            end
            if (e_wr) begin
                ref_mem[e_wa] = e_wd;
                m_wptr = 1 - ww;
            end
        end
        if (pre_en) ref_mem[pre_addr] = pre_data;

        chk("gnt",     128'(bus.gnt_o),             128'(e_gnt));
        chk("strobes", 128'({write_o, read_o}),     128'({e_wr, e_rd}));
        chk("wport",   128'({w_addr_o, w_data_o}),  128'({e_wa, e_wd}));
        chk("raddr",   128'(r_addr_o),              128'(e_ra));
        chk("rvalid",  128'(bus.rvalid_o),          128'(e_rv));
        chk("rdata",   128'(bus.rdata_o),           128'(e_rdata));
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic [1:0] req, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        rst            = r;
        pre_en         = 1'b0;
        bus.req_i      = req;
        bus.we_i       = we;
        bus.addr_i[0]  = a0;
        bus.addr_i[1]  = a1;
        bus.wdata_i[0] = d0;
        bus.wdata_i[1] = d1;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.req_i = 2'b00;
        pre_en    = 1'b1;
        pre_addr  = a;
        pre_data  = d;
        @(negedge clk);
    endtask

    localparam logic [63:0] D1  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DBF = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] AAA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] BBB = 64'h5555_5555_5555_5555;

    function automatic logic [63:0] wpat(input int who, input int a);
        return {32'(32'hC0DE_0000 + who), 32'(a)};
    endfunction

    function automatic logic [63:0] spat(input int a);
        return {32'h5EED_0000, 32'(a * 7 + 3)};
    endfunction

    initial begin
        logic [1:0] prev_gnt;
        logic [1:0] exp_g;
        int         i0, i1;
        rst = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
        drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
        drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
        chk("reset rvalid", 128'(bus.rvalid_o), 128'(2'b00));
        chk("reset rdata",  128'(bus.rdata_o),  128'(0));

        // Single write then read, no contention
        drive(1'b0, 2'b01, 2'b01, 9'h010, '0, D1, '0);
        chk("t1 gnt",    128'(bus.gnt_o), 128'(2'b01));
        chk("t1 write",  128'({write_o, w_addr_o, w_data_o}), 128'({1'b1, 9'h010, D1}));
        drive(1'b0, 2'b01, 2'b00, 9'h010, '0, '0, '0);
        chk("t1 read",   128'({bus.gnt_o, read_o, r_addr_o}), 128'({2'b01, 1'b1, 9'h010}));
        idle();
        chk("t1 rvalid", 128'(bus.rvalid_o), 128'(2'b01));
        chk("t1 rdata",  128'(bus.rdata_o),  128'(D1));

        // Write contention after reset
        drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
        drive(1'b0, 2'b11, 2'b11, 9'h001, 9'h002, wpat(0, 1), wpat(1, 2));
        chk("t2 gnt c1", 128'(bus.gnt_o), 128'(2'b01));
        drive(1'b0, 2'b11, 2'b11, 9'h003, 9'h002, wpat(0, 3), wpat(1, 2));
        chk("t2 gnt c2", 128'(bus.gnt_o), 128'(2'b10));
        drive(1'b0, 2'b11, 2'b11, 9'h003, 9'h004, wpat(0, 3), wpat(1, 4));
        chk("t2 gnt c3", 128'(bus.gnt_o), 128'(2'b01));
        drive(1'b0, 2'b11, 2'b11, 9'h005, 9'h004, wpat(0, 5), wpat(1, 4));
        chk("t2 gnt c4", 128'(bus.gnt_o), 128'(2'b10));
        for (int a = 1; a <= 4; a++) begin
            drive(1'b0, 2'b01, 2'b00, 9'(a), '0, '0, '0);
            if (a > 1) chk("t2 readback", 128'(bus.rdata_o), 128'(wpat((a - 1) % 2 == 0 ? 1 : 0, a - 1)));
        end
        idle();
        chk("t2 readback", 128'(bus.rdata_o), 128'(wpat(1, 4)));

        // Concurrent read + write, different addresses
        preload(9'h030, DBF);
        drive(1'b0, 2'b11, 2'b01, 9'h020, 9'h030, 64'h20, '0);
        chk("t3 gnt",    128'(bus.gnt_o), 128'(2'b11));
        idle();
        chk("t3 rvalid", 128'(bus.rvalid_o), 128'(2'b10));
        chk("t3 rdata",  128'(bus.rdata_o),  128'(DBF));

        // Collision: write wins, read retries and sees new data
        preload(9'h040, BBB);
        drive(1'b0, 2'b11, 2'b01, 9'h040, 9'h040, AAA, '0);
        chk("t4 gnt c1", 128'({bus.gnt_o, read_o}), 128'({2'b01, 1'b0}));
        drive(1'b0, 2'b10, 2'b00, '0, 9'h040, '0, '0);
        chk("t4 gnt c2", 128'(bus.gnt_o), 128'(2'b10));
        idle();
        chk("t4 rvalid", 128'(bus.rvalid_o), 128'(2'b10));
        chk("t4 rdata",  128'(bus.rdata_o),  128'(AAA));

        // Read stream interleave
        for (int k = 0; k < 6; k++) begin
            preload(9'(9'h100 + k), spat(9'h100 + k));
            preload(9'(9'h200 + k), spat(9'h200 + k));
        end
        i0 = 0; i1 = 0; prev_gnt = 2'b00;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 2'b11, 2'b00, 9'(9'h100 + i0), 9'(9'h200 + i1), '0, '0);
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("t5 gnt", 128'(bus.gnt_o), 128'(exp_g));
            if (k > 0) chk("t5 rvalid", 128'(bus.rvalid_o), 128'(prev_gnt));
            prev_gnt = exp_g;
            if (k % 2 == 0) i0++; else i1++;
        end
        idle();
        chk("t5 last rvalid", 128'(bus.rvalid_o), 128'(prev_gnt));
        chk("t5 last rdata",  128'(bus.rdata_o),  128'(spat(9'h200 + 3)));

        // Reset mid-read
        drive(1'b0, 2'b11, 2'b01, 9'h050, 9'h100, 64'h50, '0);
        chk("t6 gnt", 128'(bus.gnt_o), 128'(2'b11));
        drive(1'b1, 2'b11, 2'b11, 9'h060, 9'h061, 64'h60, 64'h61);
        chk("t6 rst outs", 128'({bus.gnt_o, bus.rvalid_o, write_o, read_o, w_addr_o, r_addr_o}), 128'(0));
        chk("t6 rst data", 128'({w_data_o, bus.rdata_o}), 128'(0));
        drive(1'b0, 2'b11, 2'b11, 9'h060, 9'h061, 64'h60, 64'h61);
        chk("t6 post gnt",    128'(bus.gnt_o),    128'(2'b01));
        chk("t6 post rvalid", 128'(bus.rvalid_o), 128'(2'b00));
        idle();
        chk("t6 post rvalid2", 128'(bus.rvalid_o), 128'(2'b00));
        drive(1'b0, 2'b11, 2'b00, 9'h100, 9'h101, '0, '0);
        chk("t6 read gnt", 128'(bus.gnt_o), 128'(2'b01));
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
